// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down counter / countdown timer with optional auto-reload
module down_counter_timer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_en,
    input  logic [N-1:0] data_in,
    input  logic         start,
    input  logic         pause,
    input  logic         auto_reload,
    output logic [N-1:0] count_out,
    output logic         busy,
    output logic         tc
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] reload_q, reload_d;
    logic         tc_q, tc_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load_en) begin
            count_d  = data_in;
            reload_d = data_in;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (count_q != ZERO) begin
                            state_d = ST_RUN;
                        end else begin
                            tc_d    = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (count_q > ONE) begin
                        count_d = count_q - ONE;
                    end else if (count_q == ONE) begin
                        tc_d = 1'b1;
                        if (auto_reload && (reload_q != ZERO)) begin
                            count_d = reload_q;
                        end else begin
                            count_d = ZERO;
                            state_d = ST_DONE;
                        end
                    end else begin
                        // Unreachable zero count in RUN: park in DONE rather than wrap.
                        state_d = ST_DONE;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        if (reload_q != ZERO) begin
                            count_d = reload_q;
                            state_d = ST_RUN;
                        end else begin
                            tc_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign count_out = count_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    assign tc        = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - self-checking bench for down_counter_timer
module tb_down_counter_timer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       auto_reload = 1'b0;
    logic [7:0] count_out;
    logic       busy;
    logic       tc;

    int tests_run = 0;
    int tests_failed = 0;
    bit cmp_en = 1'b0;

    down_counter_timer #(.N(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_en    (load_en),
        .data_in    (data_in),
        .start      (start),
        .pause      (pause),
        .auto_reload(auto_reload),
        .count_out  (count_out),
        .busy       (busy),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    // Behavioural model: a counter value, a stored period, and three flags.
    int m_count = 0;
    int m_reload = 0;
    bit m_active = 0;
    bit m_held = 0;
    bit m_expired = 0;
    bit m_tc = 0;

    always @(posedge clk) begin
        m_tc = 0;
        if (!reset_n) begin
            m_count = 0; m_reload = 0;
            m_active = 0; m_held = 0; m_expired = 0;
        end else if (load_en) begin
            m_count = data_in; m_reload = data_in;
            m_active = 0; m_held = 0; m_expired = 0;
        end else if (!m_active) begin
            if (start) begin
                int v;
                v = m_expired ? m_reload : m_count;
                if (v == 0) begin
                    m_tc = 1; m_expired = 1;
                end else begin
                    m_count = v; m_active = 1; m_expired = 0;
                end
            end
        end else if (m_held) begin
            if (!pause) m_held = 0;
        end else if (pause) begin
            m_held = 1;
        end else if (m_count > 1) begin
            m_count = m_count - 1;
        end else begin
            m_tc = 1;
            if (auto_reload && m_reload != 0) begin
                m_count = m_reload;
            end else begin
                m_count = 0; m_active = 0; m_expired = 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_count", int'(count_out), m_count);
            chk("model_busy", int'(busy), int'(m_active));
            chk("model_tc", int'(tc), int'(m_tc));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        load_en = 1'b1; data_in = v;
        cyc(1);
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        int seq3 [6] = '{2, 1, 3, 2, 1, 3};

        // Reset
        cyc(2);
        chk("rst_count", int'(count_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tc", int'(tc), 0);
        cmp_en = 1'b1;
        reset_n = 1'b1;

        // One-shot countdown from 5
        do_load(8'h05);
        chk("load5", int'(count_out), 5);
        chk("load5_busy", int'(busy), 0);
        pulse_start();
        chk("run5_first", int'(count_out), 5);
        chk("run5_busy", int'(busy), 1);
        for (int i = 4; i >= 1; i--) begin
            cyc(1);
            chk("run5_dec", int'(count_out), i);
            chk("run5_notc", int'(tc), 0);
        end
        cyc(1);
        chk("run5_zero", int'(count_out), 0);
        chk("run5_tc", int'(tc), 1);
        chk("run5_busy_fall", int'(busy), 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("hold_zero", int'(count_out), 0);
            chk("hold_notc", int'(tc), 0);
        end

        // Periodic mode with period 3
        auto_reload = 1'b1;
        do_load(8'h03);
        pulse_start();
        chk("auto_first", int'(count_out), 3);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("auto_seq", int'(count_out), seq3[i]);
            chk("auto_tc", int'(tc), (seq3[i] == 3) ? 1 : 0);
            chk("auto_busy", int'(busy), 1);
        end
        auto_reload = 1'b0;

        // Pause at 4
        do_load(8'h08);
        pulse_start();
        cyc(4);
        chk("pre_pause", int'(count_out), 4);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("paused_count", int'(count_out), 4);
            chk("paused_busy", int'(busy), 1);
        end
        pause = 1'b0;
        cyc(1);
        chk("resume_hold", int'(count_out), 4);
        cyc(1);
        chk("resume_dec", int'(count_out), 3);

        // Load aborts a run
        do_load(8'hFF);
        pulse_start();
        cyc(2);
        chk("ff_dec2", int'(count_out), 8'hFD);
        do_load(8'h10);
        chk("abort_count", int'(count_out), 8'h10);
        chk("abort_busy", int'(busy), 0);
        pulse_start();
        cyc(1);
        chk("after_abort_0f", int'(count_out), 8'h0F);
        cyc(1);
        chk("after_abort_0e", int'(count_out), 8'h0E);

        // Mid-run reset, then starts with nothing loaded
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        chk("midrst_count", int'(count_out), 0);
        chk("midrst_busy", int'(busy), 0);
        pulse_start();
        chk("zero_start_tc", int'(tc), 1);
        chk("zero_start_busy", int'(busy), 0);
        cyc(1);
        chk("zero_start_tc_low", int'(tc), 0);
        pulse_start();
        chk("done_start_tc", int'(tc), 1);
        chk("done_start_count", int'(count_out), 0);
        cyc(2);

        // Start held high: every expiry restarts from the stored period
        do_load(8'h02);
        start = 1'b1;
        cyc(10);
        start = 1'b0;
        cyc(4);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
